// File: rtl/cva6_rom_fetch_if.sv
// Fetch unit bus: boot ROM read port plus the core-facing instruction stream.
// master is the fetch unit, slave is the ROM/core side.
interface cva6_rom_fetch_if;
  logic [9:0]  rom_addr;
  logic [31:0] rom_rdata;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        err_o;

  modport master (
    output rom_addr, valid_o, instr_o, pc_o, err_o,
    input  rom_rdata, redirect_i, redirect_pc_i, ready_i
  );

  modport slave (
    input  rom_addr, valid_o, instr_o, pc_o, err_o,
    output rom_rdata, redirect_i, redirect_pc_i, ready_i
  );
endinterface

// File: rtl/cva6_rom_fetch.sv
// Boot ROM instruction fetcher: issues sequential word reads, buffers responses in a
// small prefetch FIFO and hands {pc, instr, err} to the core; redirects flush everything.
module cva6_rom_fetch #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_BYTES = 1024
) (
  input logic              clk,
  input logic              rst_n,
  cva6_rom_fetch_if.master bus
);

  localparam logic [31:0] Nop  = 32'h0000_0013;
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          head_q, head_d;
  entry_t          push_entry;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] remain;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic            rsp_fault_q, rsp_fault_d;
  logic            inflight_q, inflight_d;
  logic            halted_q, halted_d;
  logic            fault, issue, push, pop, valid;

  assign fault = (fetch_pc_q[1:0] != 2'b00) || (fetch_pc_q >= ROM_BYTES);
  assign valid = (count_q != '0);

  // Credit counts buffered plus in-flight words only; a same-cycle pop earns no credit.
  assign issue = !bus.redirect_i && !halted_q &&
                 ((32'(count_q) + 32'(inflight_q)) < DEPTH);
  assign push  = inflight_q && !bus.redirect_i;
  assign pop   = valid && bus.ready_i && !bus.redirect_i;

  assign push_entry = '{pc:    rsp_pc_q,
                        instr: rsp_fault_q ? Nop : bus.rom_rdata,
                        err:   rsp_fault_q};

  assign bus.rom_addr = fetch_pc_q[11:2];
  assign bus.valid_o  = valid;
  assign bus.instr_o  = head_q.instr;
  assign bus.pc_o     = head_q.pc;
  assign bus.err_o    = head_q.err;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_fault_d = rsp_fault_q;
    inflight_d  = inflight_q;
    halted_d    = halted_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    head_d      = head_q;
    remain      = count_q - CntW'(pop);

    if (bus.redirect_i) begin
      fetch_pc_d = bus.redirect_pc_i;
      halted_d   = 1'b0;
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        rsp_pc_d    = fetch_pc_q;
        rsp_fault_d = fault;
        fetch_pc_d  = fetch_pc_q + 32'd4;
        if (fault) begin
          halted_d = 1'b1;
        end
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
      // Head mirror: oldest surviving entry, else the word arriving now, else hold.
      if (remain != '0) begin
        head_d = mem_q[rd_ptr_d];
      end else if (push) begin
        head_d = push_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q  <= RESET_PC;
      rsp_pc_q    <= '0;
      rsp_fault_q <= 1'b0;
      inflight_q  <= 1'b0;
      halted_q    <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= '{pc: 32'h0, instr: Nop, err: 1'b0};
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_fault_q <= rsp_fault_d;
      inflight_q  <= inflight_d;
      halted_q    <= halted_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == CntW'(DEPTH))));

endmodule
